// File: rtl/password_enroll.sv
// password_enroll: two-pass switch-entered code enrollment with HEX progress/result display
module password_enroll #(
  parameter int                  DIGITS       = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h2018,
  parameter int                  HOLD_CYCLES  = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [9:0]            sw_pulse,
  output logic [4*DIGITS-1:0]   code_q,
  output logic                  busy,
  output logic                  enroll_ok,
  output logic                  enroll_err,
  output logic [6:0]            HEX0,
  output logic [6:0]            HEX1,
  output logic [6:0]            HEX2,
  output logic [6:0]            HEX3
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] DASH  = 7'h3F;
  localparam logic [6:0] UNDER = 7'h77;

  typedef enum logic [2:0] {IDLE, ENTER, CONFIRM, DONE, ERROR} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] code_d;
  logic                ok_q, ok_d, err_q, err_d;
  logic [3:0]          digit;
  logic                valid, last;
  int                  nib;
  logic [6:0]          hex [4];

  // one-hot switch pulse to digit value; multi-hot flagged as invalid
  always_comb begin
    digit = '0;
    for (int i = 0; i < 10; i++) if (sw_pulse[i]) digit = 4'(i);
    valid = (sw_pulse != '0) && ((sw_pulse & (sw_pulse - 10'd1)) == '0);
    last  = cnt_q == CW'(DIGITS - 1);
    nib   = 4 * (DIGITS - 1 - int'(cnt_q));
  end

  // enrollment FSM: start overrides everything, shadow is written MS nibble first
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    code_d   = code_q;
    if (start) begin
      state_d = ENTER;
      cnt_d   = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ENTER: if (sw_pulse != '0) begin
          if (!valid) state_d = ERROR;
          else begin
            shadow_d[nib +: 4] = digit;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            state_d = last ? CONFIRM : ENTER;
          end
        end
        CONFIRM: if (sw_pulse != '0) begin
          if (!valid || shadow_q[nib +: 4] != digit) state_d = ERROR;
          else if (last) begin
            state_d = DONE;
            code_d  = shadow_q;
            cnt_d   = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
        DONE, ERROR: begin
          state_d = hold_q == HW'(HOLD_CYCLES - 1) ? IDLE : state_q;
          hold_d  = hold_q == HW'(HOLD_CYCLES - 1) ? '0 : hold_q + 1'b1;
        end
        default: ;
      endcase
    end
    ok_d  = state_d == DONE  && state_q != DONE;
    err_d = state_d == ERROR && state_q != ERROR;
  end

  // state, counters, shadow and committed code registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      shadow_q <= '0;
      code_q   <= DEFAULT_CODE;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end

  // display decode straight from registered state and digit count
  always_comb begin
    for (int i = 0; i < 4; i++)
      hex[i] = (state_q == ENTER   && i < int'(cnt_q)) ? DASH  :
               (state_q == CONFIRM && i < int'(cnt_q)) ? UNDER : BLANK;
    if (state_q == DONE) begin
      hex[3] = 7'h21;
      hex[2] = 7'h23;
      hex[1] = 7'h2B;
      hex[0] = 7'h06;
    end
    if (state_q == ERROR) begin
      hex[3] = 7'h06;
      hex[2] = 7'h2F;
      hex[1] = 7'h2F;
      hex[0] = BLANK;
    end
  end

  assign busy       = state_q == ENTER || state_q == CONFIRM;
  assign enroll_ok  = ok_q;
  assign enroll_err = err_q;
  assign HEX0       = hex[0];
  assign HEX1       = hex[1];
  assign HEX2       = hex[2];
  assign HEX3       = hex[3];
endmodule

// File: tb/tb_password_enroll.sv
// tb_password_enroll: directed vector table plus reset/start corner sequences
module tb_password_enroll;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  sw_pulse = '0;
  logic [15:0] code_q;
  logic        busy, enroll_ok, enroll_err;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  localparam logic [6:0] B = 7'h7F, D = 7'h3F, U = 7'h77;

  typedef struct {
    logic        start;
    logic [9:0]  sw;
    logic        busy, ok, err;
    logic [15:0] code;
    logic [6:0]  h3, h2, h1, h0;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  password_enroll #(.DIGITS(4), .DEFAULT_CODE(16'h2018), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sw_pulse(sw_pulse), .code_q(code_q),
    .busy(busy), .enroll_ok(enroll_ok), .enroll_err(enroll_err),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] p(input int d);
    p = 10'd1 << d;
  endfunction

  function automatic void add(input logic s, input logic [9:0] sw, input logic b, input logic o,
                              input logic e, input logic [15:0] c, input logic [6:0] h3,
                              input logic [6:0] h2, input logic [6:0] h1, input logic [6:0] h0);
    vq.push_back('{s, sw, b, o, e, c, h3, h2, h1, h0});
  endfunction

  task automatic check(input string name, input logic b, input logic o, input logic e,
                       input logic [15:0] c, input logic [6:0] h3, input logic [6:0] h2,
                       input logic [6:0] h1, input logic [6:0] h0);
    logic [46:0] got, exp;
    got = {busy, enroll_ok, enroll_err, code_q, HEX3, HEX2, HEX1, HEX0};
    exp = {b, o, e, c, h3, h2, h1, h0};
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got busy=%b ok=%b err=%b code=%h hex3..0=%h %h %h %h, want busy=%b ok=%b err=%b code=%h hex3..0=%h %h %h %h",
               name, busy, enroll_ok, enroll_err, code_q, HEX3, HEX2, HEX1, HEX0,
               b, o, e, c, h3, h2, h1, h0);
    end
  endtask

  task automatic apply(input logic s, input logic [9:0] sw);
    start = s;
    sw_pulse = sw;
    @(posedge clk);
    #1;
    start = 1'b0;
    sw_pulse = '0;
  endtask

  initial begin
    // successful enrollment 5739, then hold timeout and ignored switch in IDLE
    add(1, 0,     1, 0, 0, 16'h2018, B, B, B, B);
    add(0, p(5),  1, 0, 0, 16'h2018, B, B, B, D);
    add(0, p(7),  1, 0, 0, 16'h2018, B, B, D, D);
    add(0, p(3),  1, 0, 0, 16'h2018, B, D, D, D);
    add(0, p(9),  1, 0, 0, 16'h2018, B, B, B, B);
    add(0, p(5),  1, 0, 0, 16'h2018, B, B, B, U);
    add(0, p(7),  1, 0, 0, 16'h2018, B, B, U, U);
    add(0, p(3),  1, 0, 0, 16'h2018, B, U, U, U);
    add(0, p(9),  0, 1, 0, 16'h5739, 7'h21, 7'h23, 7'h2B, 7'h06);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 16'h5739, 7'h21, 7'h23, 7'h2B, 7'h06);
    add(0, 0,     0, 0, 0, 16'h5739, B, B, B, B);
    add(0, p(3),  0, 0, 0, 16'h5739, B, B, B, B);
    // confirm mismatch on third digit
    add(1, 0,     1, 0, 0, 16'h5739, B, B, B, B);
    add(0, p(5),  1, 0, 0, 16'h5739, B, B, B, D);
    add(0, p(7),  1, 0, 0, 16'h5739, B, B, D, D);
    add(0, p(3),  1, 0, 0, 16'h5739, B, D, D, D);
    add(0, p(9),  1, 0, 0, 16'h5739, B, B, B, B);
    add(0, p(5),  1, 0, 0, 16'h5739, B, B, B, U);
    add(0, p(7),  1, 0, 0, 16'h5739, B, B, U, U);
    add(0, p(4),  0, 0, 1, 16'h5739, 7'h06, 7'h2F, 7'h2F, B);
    add(0, 0,     0, 0, 0, 16'h5739, 7'h06, 7'h2F, 7'h2F, B);
    // start out of ERROR, then multi-hot in ENTER
    add(1, 0,     1, 0, 0, 16'h5739, B, B, B, B);
    add(0, 10'b0000000101, 0, 0, 1, 16'h5739, 7'h06, 7'h2F, 7'h2F, B);
    add(0, 0,     0, 0, 0, 16'h5739, 7'h06, 7'h2F, 7'h2F, B);
    // restart mid-entry, then 4444 twice
    add(1, p(1),  1, 0, 0, 16'h5739, B, B, B, B);
    add(0, p(1),  1, 0, 0, 16'h5739, B, B, B, D);
    add(0, p(2),  1, 0, 0, 16'h5739, B, B, D, D);
    add(1, 0,     1, 0, 0, 16'h5739, B, B, B, B);
    add(0, p(4),  1, 0, 0, 16'h5739, B, B, B, D);
    add(0, p(4),  1, 0, 0, 16'h5739, B, B, D, D);
    add(0, p(4),  1, 0, 0, 16'h5739, B, D, D, D);
    add(0, p(4),  1, 0, 0, 16'h5739, B, B, B, B);
    add(0, p(4),  1, 0, 0, 16'h5739, B, B, B, U);
    add(0, p(4),  1, 0, 0, 16'h5739, B, B, U, U);
    add(0, p(4),  1, 0, 0, 16'h5739, B, U, U, U);
    add(0, p(4),  0, 1, 0, 16'h4444, 7'h21, 7'h23, 7'h2B, 7'h06);
    add(0, 0,     0, 0, 0, 16'h4444, 7'h21, 7'h23, 7'h2B, 7'h06);

    repeat (2) @(posedge clk);
    #1;
    check("reset_held", 0, 0, 0, 16'h2018, B, B, B, B);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 0, 0, 0, 16'h2018, B, B, B, B);

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].start, vq[i].sw);
      check($sformatf("vec%0d", i), vq[i].busy, vq[i].ok, vq[i].err, vq[i].code,
            vq[i].h3, vq[i].h2, vq[i].h1, vq[i].h0);
    end

    // asynchronous reset in the middle of CONFIRM
    apply(1, 0);
    apply(0, p(1));
    apply(0, p(2));
    apply(0, p(3));
    apply(0, p(4));
    apply(0, p(1));
    check("mid_confirm", 1, 0, 0, 16'h4444, B, B, B, U);
    #2 rst = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 16'h2018, B, B, B, B);
    @(posedge clk);
    #1 rst = 1'b1;
    // start with a simultaneous switch pulse: pulse dropped, count starts at zero
    apply(1, p(6));
    check("start_sw_same", 1, 0, 0, 16'h2018, B, B, B, B);
    apply(0, p(6));
    check("first_digit_after", 1, 0, 0, 16'h2018, B, B, B, D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
